// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU function codes and controller state encoding shared by the arbiter
package alu_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_AND   = 4'b0101;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_SLT   = 4'b1101;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;
endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: first valid requester searching upward from ptr; a constant-zero ptr gives lowest-index priority
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx
);
  int j;
  // scanning downward lets the candidate nearest ptr overwrite the rest
  always_comb begin
    gnt = '0;
    idx = '0;
    j = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      j = (j >= N_REQ) ? j - N_REQ : j;
      if (valid[j]) begin
        gnt = N_REQ'(1) << j;
        idx = PW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among N_REQ requesters; ALU_ARB_RR_EN selects round-robin, else fixed priority
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [32*N_REQ-1:0] req_a,
  input  logic [32*N_REQ-1:0] req_b,
  input  logic [5*N_REQ-1:0] req_shamt,
  input  logic [4*N_REQ-1:0] req_alufn,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [31:0]        rsp_r,
  output logic [3:0]         rsp_flags,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [4:0]         alu_shamt,
  output logic [3:0]         alu_alufn,
  input  logic [31:0]        alu_r,
  input  logic               alu_cf,
  input  logic               alu_zf,
  input  logic               alu_vf,
  input  logic               alu_sf
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_t state, nxt;
  logic [PW-1:0] ptr, idx, w;
  logic [N_REQ-1:0] gnt;
  logic accept;
  rr_picker #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .valid(req_valid),
    .ptr  (ptr),
    .gnt  (gnt),
    .idx  (idx)
  );
  assign accept    = (state == IDLE) && |req_valid;
  assign req_ready = (state == IDLE) ? gnt : '0;
  assign rsp_valid = (state == RESP) ? N_REQ'(1) << w : '0;
  always_comb nxt = (state == IDLE) ? (accept ? EXEC : IDLE) : (state == EXEC) ? RESP : IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w         <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shamt <= '0;
      alu_alufn <= '0;
      rsp_r     <= '0;
      rsp_flags <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        alu_a     <= req_a[32*idx +: 32];
        alu_b     <= req_b[32*idx +: 32];
        alu_shamt <= req_shamt[5*idx +: 5];
        alu_alufn <= req_alufn[4*idx +: 4];
        w         <= idx;
      end
      if (state == EXEC) begin
        rsp_r     <= alu_r;
        rsp_flags <= {alu_cf, alu_zf, alu_vf, alu_sf};
      end
    end
  end
`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (accept) ptr <= (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a timeline model and a behavioural ALU
module tb_alu_arbiter;
  localparam int N = 2;
  logic clk = 0, rst = 1;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [32*N-1:0] req_a, req_b;
  logic [5*N-1:0] req_shamt;
  logic [4*N-1:0] req_alufn;
  logic [31:0] rsp_r, alu_a, alu_b, alu_r;
  logic [3:0] rsp_flags, alu_alufn;
  logic [4:0] alu_shamt;
  logic alu_cf, alu_zf, alu_vf, alu_sf;
  int n_tests = 0, n_fail = 0, cyc = 0;
  int free_at, rsp_at, rsp_owner, mptr, last_cyc;
  logic [31:0] exp_r;
  logic [3:0] exp_fl;
  logic [35:0] pend;
  logic [N-1:0] last_ready, last_rsp;
  int grants[$], gcyc[$];
  bit rand_on, rand_new;
  int rq_st[N];

  alu_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .req_alufn(req_alufn),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_alufn(alu_alufn),
    .alu_r(alu_r), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_sf(alu_sf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] sh, input logic [3:0] fn);
    logic [32:0] s;
    logic [31:0] r;
    logic cf, vf;
    s = '0; cf = 0; vf = 0;
    case (fn)
      4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cf = s[32]; vf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0001: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cf = s[32]; vf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0011: r = b;
      4'b0100: r = a | b;
      4'b0101: r = a & b;
      4'b0111: r = a ^ b;
      4'b1000: r = a << sh;
      4'b1001: r = a >> sh;
      4'b1010: r = $signed(a) >>> sh;
      4'b1101: r = {31'b0, $signed(a) < $signed(b)};
      4'b1111: r = {31'b0, a < b};
      default: r = 32'hdead_0000 | {28'b0, fn};
    endcase
    return {cf, r == 32'b0, vf, r[31], r};
  endfunction

  always_comb {alu_cf, alu_zf, alu_vf, alu_sf, alu_r} = alu_f(alu_a, alu_b, alu_shamt, alu_alufn);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: an accept at cycle t answers at t+2 and frees the block at t+3
  task automatic check_cycle();
    logic [N-1:0] er;
    int w;
    last_ready = req_ready;
    last_rsp = rsp_valid;
    last_cyc = cyc;
    if (rst) begin
      free_at = 0; rsp_at = -1; exp_r = '0; exp_fl = '0; mptr = 0;
      return;
    end
    er = '0;
    w = -1;
    if (cyc >= free_at && |req_valid) begin
      for (int k = 0; k < N; k++) if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
      er[w] = 1'b1;
    end
    chk("req_ready", req_ready, er);
    if (cyc == rsp_at) begin
      exp_r = pend[31:0];
      exp_fl = pend[35:32];
    end
    chk("rsp_valid", rsp_valid, (cyc == rsp_at) ? N'(1) << rsp_owner : '0);
    chk("rsp_r", rsp_r, exp_r);
    chk("rsp_flags", rsp_flags, exp_fl);
    if (w >= 0) begin
      grants.push_back(w);
      gcyc.push_back(cyc);
      rsp_at = cyc + 2;
      free_at = cyc + 3;
      rsp_owner = w;
      pend = alu_f(req_a[32*w +: 32], req_b[32*w +: 32], req_shamt[5*w +: 5], req_alufn[4*w +: 4]);
`ifdef ALU_ARB_RR_EN
      mptr = (w + 1) % N;
`endif
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] fn);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_shamt[5*i +: 5] = sh;
    req_alufn[4*i +: 4] = fn;
  endtask

  task automatic drive_rand();
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      if (rq_st[i] == 1 && last_ready[i]) begin
        req_valid[i] = 1'b0;
        rq_st[i] = 2;
      end else if (rq_st[i] == 2 && last_rsp[i]) rq_st[i] = 0;
      if (rand_new && rq_st[i] == 0 && $urandom_range(2) == 0) begin
        a = $urandom;
        set_ops(i, a, ($urandom_range(3) == 0) ? a : $urandom, 5'($urandom), 4'($urandom));
        req_valid[i] = 1'b1;
        rq_st[i] = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #2;
    if (rand_on) drive_rand();
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [3:0] fn, input logic [31:0] er, input int ef);
    int n, rc;
    set_ops(i, a, b, sh, fn);
    req_valid[i] = 1'b1;
    n = -1;
    for (int t = 0; t < 10 && n < 0; t++) begin
      step();
      if (last_ready[i]) n = last_cyc;
    end
    req_valid[i] = 1'b0;
    chk("accept_seen", n >= 0, 1);
    if (n < 0) return;
    rc = -1;
    for (int t = 0; t < 10 && rc < 0; t++) begin
      step();
      if (last_rsp[i]) rc = last_cyc;
    end
    chk("rsp_latency", rc - n, 2);
    chk("op_result", rsp_r, er);
    if (ef >= 0) chk("op_flags", rsp_flags, ef[3:0]);
  endtask

  initial begin
    int n;
    req_valid = '0; req_a = '0; req_b = '0; req_shamt = '0; req_alufn = '0;
    rand_on = 0; rand_new = 0;
    free_at = 0; rsp_at = -1; mptr = 0;
    for (int i = 0; i < N; i++) rq_st[i] = 0;
    rst = 1;
    step();
    step();
    rst = 0;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_shamt", alu_shamt, 0);
    chk("rst_alu_alufn", alu_alufn, 0);
    chk("rst_rsp_r", rsp_r, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);

    run_op(0, 32'd5, 32'd7, 5'd0, 4'b0000, 32'd12, 4'b0000);
    run_op(1, 32'd3, 32'd3, 5'd0, 4'b0001, 32'd0, 4'b1100);
    run_op(0, 32'd1, 32'd2, 5'd0, 4'b1111, 32'd1, -1);
    run_op(1, 32'd2, 32'd1, 5'd0, 4'b1111, 32'd0, -1);
    run_op(0, 32'h8000_0010, 32'd0, 5'd4, 4'b1010, 32'hf800_0001, -1);

    rst = 1;
    step();
    rst = 0;
    grants.delete();
    gcyc.delete();
    set_ops(0, 32'd10, 32'd1, 5'd0, 4'b0000);
    set_ops(1, 32'd20, 32'd2, 5'd0, 4'b0001);
    req_valid = '1;
    repeat (12) step();
    chk("grant_count", grants.size() >= 4, 1);
    for (int k = 0; k < 4 && k < grants.size(); k++) begin
`ifdef ALU_ARB_RR_EN
      chk($sformatf("grant_order_%0d", k), grants[k], k % 2);
`else
      chk($sformatf("grant_order_%0d", k), grants[k], 0);
`endif
      chk($sformatf("grant_spacing_%0d", k), gcyc[k] - gcyc[0], 3 * k);
    end
    req_valid = '0;
    repeat (4) step();

    set_ops(0, 32'd5, 32'd7, 5'd0, 4'b0000);
    req_valid[0] = 1'b1;
    n = -1;
    for (int t = 0; t < 10 && n < 0; t++) begin
      step();
      if (last_ready[0]) n = last_cyc;
    end
    chk("mid_accept_seen", n >= 0, 1);
    req_valid[0] = 1'b0;
    rst = 1;
    step();
    rst = 0;
    step();
    chk("mid_rst_rsp_valid", last_rsp, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_alufn", alu_alufn, 0);
    chk("mid_rst_rsp_r", rsp_r, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    run_op(0, 32'd9, 32'd1, 5'd0, 4'b0001, 32'd8, 4'b1000);

    rand_on = 1;
    rand_new = 1;
    repeat (600) step();
    rand_new = 0;
    repeat (30) step();
    rand_on = 0;
    chk("drain_idle", req_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `prv32_ALU` instance between up to four requesters, such as the execute stage, the branch/address unit and a CSR read-modify-write path. Each requester uses a valid/ready request channel and receives a one-cycle response pulse. The block selects one request, registers its operands into the ALU, captures the result and flags, and returns them to the winning requester. It sits between the requesters and the ALU, and is the only driver of the ALU inputs.

## Interface
Parameters:
- `N_REQ`, default 2. Number of requesters; legal values are 1 to 4.

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — reset, synchronous and active-high.
- `req_valid`  in  N_REQ  — request pending, one bit per requester.
- `req_ready`  out  N_REQ  — request accepted this cycle; at most one bit set.
- `req_a`, `req_b`  in  32*N_REQ  — operands; requester i occupies slice [32i+31:32i].
- `req_shamt`  in  5*N_REQ  — shift amount per requester.
- `req_alufn`  in  4*N_REQ  — ALU function code per requester.
- `rsp_valid`  out  N_REQ  — one-cycle response pulse to the owning requester.
- `rsp_r`  out  32  — registered result, shared by all requesters.
- `rsp_flags`  out  4  — registered {cf, zf, vf, sf}, shared by all requesters.
- `alu_a`, `alu_b`  out  32  — ALU operands, driven directly from registers.
- `alu_shamt`  out  5, `alu_alufn`  out  4  — ALU shift amount and function code, registered.
- `alu_r`  in  32, `alu_cf`, `alu_zf`, `alu_vf`, `alu_sf`  in  1 each  — ALU result and flags.

## Operation
The controller is a three-state FSM: IDLE → EXEC → RESP → IDLE.

- **IDLE**
  - If any `req_valid` bit is set, the picker chooses winner w.
  - `req_ready[w]` = 1 in this same cycle. This is a combinational path from `req_valid` to `req_ready`, gated by state == IDLE.
  - On the clock edge: latch requester w's a, b, shamt and alufn into the operand registers, record w, and go to EXEC.
  - If no request is valid, stay in IDLE and hold the operand registers.
- **EXEC**
  - The operand registers drive the ALU.
  - On the clock edge: capture `alu_r` into `rsp_r` and the four flags into `rsp_flags`, then go to RESP.
- **RESP**
  - `rsp_valid[w]` = 1 for exactly one cycle, then return to IDLE.
  - `rsp_r` and `rsp_flags` hold their values until the next capture.
- **Requester rules**
  - A requester holds `req_valid` and its operands stable until it sees `req_ready`.
  - A requester must not reissue a request before its `rsp_valid`.
- **Picker**
  - Round-robin mode: search starts at index `ptr`. After a grant to w, `ptr` = (w+1) mod N_REQ, and the pointer wraps at N_REQ.
  - When only one requester is valid, it wins regardless of `ptr`.
- **No interpretation of alufn:** the block passes `alufn` through unchanged. Undefined codes produce whatever the ALU returns.
- **Reset values**
  - State is IDLE and `ptr` is 0.
  - `req_ready`, `rsp_valid`, `rsp_r`, `rsp_flags` and all `alu_*` outputs are 0.
- **Reset mid-operation:** an in-flight operation in EXEC or RESP is abandoned. No `rsp_valid` is issued for it, and the requester must reissue after reset.

## Timing
- Accept in cycle n (`req_valid & req_ready`) → `rsp_valid` is high in cycle n+2.
- Throughput is one operation every 3 cycles.
- `req_ready` is low in EXEC and RESP.
- A new request can be accepted in the cycle immediately after RESP.
- The ALU operand path is registered. The only combinational path through the block is `req_valid` → picker → `req_ready`.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration, with the `ptr` register as described above.
- `ALU_ARB_RR_EN` undefined: fixed priority, where the lowest valid index always wins. `ptr` is removed.
  - Starvation of higher indices is permitted in this mode.

## Structure
- Put ALU function-code constants and the FSM state encodings in the shared definitions include.
  - ALU function codes: ADD 4'b0000, SUB 4'b0001, PASSB 4'b0011, OR 4'b0100, AND 4'b0101, XOR 4'b0111, SLL/SRL/SRA 4'b1000/4'b1001/4'b1010, SLT 4'b1101, SLTU 4'b1111.
  - FSM states: IDLE, EXEC, RESP.
- One sub-module, `rr_picker`:
  - Inputs: `N_REQ`-bit valid vector and `ptr`.
  - Output: one-hot grant plus its index.
  - It degenerates to a lowest-index priority encoder when `ALU_ARB_RR_EN` is undefined.

## Test plan
- **Single ADD:** requester 0 issues alufn 0000, a=5, b=7, accepted at cycle n. Required: `rsp_valid[0]` at n+2, `rsp_r`=12, zf=0.
- **SUB equal operands:** requester 1 issues alufn 0001, a=3, b=3. Required: `rsp_r`=0, zf=1, cf=1; `rsp_valid[0]` stays 0.
- **SLTU:** alufn 1111, a=1, b=2. Required: `rsp_r`=1. Then a=2, b=1 returns `rsp_r`=0.
- **Round-robin contention (RR_EN defined):** both requesters valid continuously from reset. Required grant order 0,1,0,1, one grant every 3 cycles, at most one `req_ready` bit set per cycle.
- **Fixed priority (RR_EN undefined):** same stimulus as the round-robin case. Required: requester 0 wins every grant and `req_ready[1]` never asserts.
- **Reset mid-operation:** assert `rst` in the EXEC cycle of an ADD. Required: no `rsp_valid` pulse, all outputs 0 in the following cycle, FSM back in IDLE; a new request completes normally.
